// File: rtl/rob_param_if.sv
// ---------------------------------------------------------------------------
// rob_param_if
// Bundles every non-clock/reset signal of the reorder buffer.
//   master : dispatch / execute / operand-read side (drives requests)
//   slave  : the reorder buffer itself
// Groups: allocation (alloc_*), writeback (wb_*), branch resolution (br_*),
// operand lookup (rd_*), retirement (commit_*), flush reporting
// (redirect_*, exp_*), occupancy status (rob_*).
// ---------------------------------------------------------------------------
interface rob_param_if #(
  parameter int DEPTH    = 32,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int AREG_W   = 5,
  parameter int WB_PORTS = 4,
  parameter int EXP_W    = 4
);
  localparam int TW = $clog2(DEPTH);

  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [PC_W-1:0]            alloc_pc;
  logic [AREG_W-1:0]          alloc_dst_addr;
  logic                       alloc_dst_wen;
  logic [TW-1:0]              alloc_tag;

  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*TW-1:0]     wb_tag;
  logic [WB_PORTS*DATA_W-1:0] wb_data;
  logic [WB_PORTS-1:0]        wb_exp;
  logic [WB_PORTS*EXP_W-1:0]  wb_exp_code;

  logic                       br_valid;
  logic [TW-1:0]              br_tag;
  logic                       br_mispredict;
  logic [PC_W-1:0]            br_target;
  logic [DATA_W-1:0]          br_data;

  logic [2*TW-1:0]            rd_tag;
  logic [1:0]                 rd_req;
  logic [1:0]                 rd_hit;
  logic [2*DATA_W-1:0]        rd_data;

  logic [1:0]                 commit_valid;
  logic [2*AREG_W-1:0]        commit_dst_addr;
  logic [1:0]                 commit_dst_wen;
  logic [2*DATA_W-1:0]        commit_data;

  logic                       redirect_valid;
  logic [PC_W-1:0]            redirect_pc;
  logic                       exp_valid;
  logic [EXP_W-1:0]           exp_code;
  logic [PC_W-1:0]            exp_pc;

  logic [TW:0]                rob_count;
  logic                       rob_full;
  logic                       rob_empty;

  modport master (
    output alloc_valid, alloc_pc, alloc_dst_addr, alloc_dst_wen,
    output wb_valid, wb_tag, wb_data, wb_exp, wb_exp_code,
    output br_valid, br_tag, br_mispredict, br_target, br_data,
    output rd_tag, rd_req,
    input  alloc_ready, alloc_tag, rd_hit, rd_data,
    input  commit_valid, commit_dst_addr, commit_dst_wen, commit_data,
    input  redirect_valid, redirect_pc, exp_valid, exp_code, exp_pc,
    input  rob_count, rob_full, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_dst_addr, alloc_dst_wen,
    input  wb_valid, wb_tag, wb_data, wb_exp, wb_exp_code,
    input  br_valid, br_tag, br_mispredict, br_target, br_data,
    input  rd_tag, rd_req,
    output alloc_ready, alloc_tag, rd_hit, rd_data,
    output commit_valid, commit_dst_addr, commit_dst_wen, commit_data,
    output redirect_valid, redirect_pc, exp_valid, exp_code, exp_pc,
    output rob_count, rob_full, rob_empty
  );
endinterface

// File: rtl/rob_param.sv
// ---------------------------------------------------------------------------
// rob_param
// Parameterised reorder buffer with in-order dual-lane retirement.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - rob_param_if.slave: allocation, writeback, branch resolution,
//          operand lookup, commit lanes, redirect/exception report, status
// A head that completes with an exception, or a mispredicted head that
// retires, flushes the whole buffer and spends one cycle in FLUSH, during
// which the exception or redirect is reported.
// ---------------------------------------------------------------------------
module rob_param #(
  parameter int DEPTH    = 32,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int AREG_W   = 5,
  parameter int WB_PORTS = 4,
  parameter int EXP_W    = 4
) (
  input logic        clk,
  input logic        rst,
  rob_param_if.slave bus
);
  localparam int TW = $clog2(DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  state_t r_state, w_state_next;

  logic [TW:0]        r_wptr, r_rptr, w_wptr_next, w_rptr_next;
  logic [DEPTH-1:0]   r_valid, r_done, r_exp, r_mis, r_wen;
  logic [PC_W-1:0]    r_pc     [DEPTH];
  logic [AREG_W-1:0]  r_dst    [DEPTH];
  logic [DATA_W-1:0]  r_data   [DEPTH];
  logic [EXP_W-1:0]   r_code   [DEPTH];
  logic [PC_W-1:0]    r_target [DEPTH];

  logic               r_fl_exp, r_fl_mis;
  logic [PC_W-1:0]    r_fl_pc;
  logic [EXP_W-1:0]   r_fl_code;
  logic [1:0]         r_rd_hit;
  logic [2*DATA_W-1:0] r_rd_data;

  logic [TW:0]        w_count;
  logic               w_full, w_run;
  logic [TW-1:0]      w_head, w_head1, w_alloc_tag;
  logic               w_head_done, w_lane0, w_lane1;
  logic               w_flush_exp, w_flush_mis, w_flush;
  logic               w_alloc_ready, w_alloc_fire;
  logic [1:0]         w_ncommit;

  // Per-entry writeback decode results (not gated by entry validity so the
  // operand bypass can reuse them).
  logic [DEPTH-1:0]   w_wr_hit, w_wr_is_br, w_wr_exp;
  logic [DATA_W-1:0]  w_wr_data [DEPTH];
  logic [EXP_W-1:0]   w_wr_code [DEPTH];

  assign w_count     = r_wptr - r_rptr;
  assign w_full      = (w_count == (TW+1)'(DEPTH));
  assign w_run       = (r_state == ST_RUN);
  assign w_head      = r_rptr[TW-1:0];
  assign w_head1     = w_head + TW'(1);
  assign w_alloc_tag = r_wptr[TW-1:0];

  // Retirement decisions use only registered state, so a result written
  // this cycle becomes visible to the head check on the next cycle.
  assign w_head_done = w_run && r_valid[w_head] && r_done[w_head];
  assign w_lane0     = w_head_done && !r_exp[w_head];
  assign w_lane1     = w_lane0 && !r_mis[w_head] && r_valid[w_head1] &&
                       r_done[w_head1] && !r_exp[w_head1] && !r_mis[w_head1];
  assign w_flush_exp = w_head_done && r_exp[w_head];
  assign w_flush_mis = w_lane0 && r_mis[w_head];
  assign w_flush     = w_flush_exp || w_flush_mis;

  assign w_alloc_ready = w_run && !w_full && !w_flush;
  assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
  assign w_ncommit     = {1'b0, w_lane0} + {1'b0, w_lane1};

  // Writeback decode: branch first, then ports from highest to lowest so
  // the lowest-numbered matching port overrides everything else.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
    logic              l_hit, l_is_br, l_exp;
    logic [DATA_W-1:0] l_data;
    logic [EXP_W-1:0]  l_code;
    always_comb begin
      l_hit   = 1'b0;
      l_is_br = 1'b0;
      l_exp   = 1'b0;
      l_data  = '0;
      l_code  = '0;
      if (bus.br_valid && bus.br_tag == TW'(gi)) begin
        l_hit   = 1'b1;
        l_is_br = 1'b1;
        l_data  = bus.br_data;
      end
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (bus.wb_valid[p] && bus.wb_tag[p*TW +: TW] == TW'(gi)) begin
          l_hit   = 1'b1;
          l_is_br = 1'b0;
          l_data  = bus.wb_data[p*DATA_W +: DATA_W];
          l_exp   = bus.wb_exp[p];
          l_code  = bus.wb_exp_code[p*EXP_W +: EXP_W];
        end
      end
    end
    assign w_wr_hit[gi]   = l_hit;
    assign w_wr_is_br[gi] = l_is_br;
    assign w_wr_exp[gi]   = l_exp;
    assign w_wr_data[gi]  = l_data;
    assign w_wr_code[gi]  = l_code;
  end

  // FSM
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_flush) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Pointers: a flush collapses the buffer onto the post-commit read pointer.
  always_comb begin
    w_rptr_next = r_rptr + (TW+1)'(w_ncommit);
    w_wptr_next = w_flush ? w_rptr_next : r_wptr + (TW+1)'(w_alloc_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_next;
      r_rptr <= w_rptr_next;
    end
  end

  // Entry status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_done  <= '0;
      r_exp   <= '0;
      r_mis   <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_flush)
          r_valid[e] <= 1'b0;
        else if (w_alloc_fire && w_alloc_tag == TW'(e))
          r_valid[e] <= 1'b1;
        else if ((w_lane0 && w_head == TW'(e)) || (w_lane1 && w_head1 == TW'(e)))
          r_valid[e] <= 1'b0;

        if (w_alloc_fire && w_alloc_tag == TW'(e)) begin
          r_done[e] <= 1'b0;
          r_exp[e]  <= 1'b0;
          r_mis[e]  <= 1'b0;
        end else if (w_wr_hit[e] && r_valid[e]) begin
          r_done[e] <= 1'b1;
          if (w_wr_is_br[e]) r_mis[e] <= bus.br_mispredict;
          else               r_exp[e] <= w_wr_exp[e];
        end
      end
    end
  end

  // Entry payload (no reset needed: qualified by the flags above)
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_alloc_fire && w_alloc_tag == TW'(e)) begin
        r_pc[e]  <= bus.alloc_pc;
        r_dst[e] <= bus.alloc_dst_addr;
        r_wen[e] <= bus.alloc_dst_wen;
      end
      if (w_wr_hit[e] && r_valid[e]) begin
        r_data[e] <= w_wr_data[e];
        if (w_wr_is_br[e]) r_target[e] <= bus.br_target;
        else               r_code[e]   <= w_wr_code[e];
      end
    end
  end

  // Capture what the FLUSH cycle has to report.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fl_exp  <= 1'b0;
      r_fl_mis  <= 1'b0;
      r_fl_pc   <= '0;
      r_fl_code <= '0;
    end else if (w_flush) begin
      r_fl_exp  <= w_flush_exp;
      r_fl_mis  <= w_flush_mis;
      r_fl_pc   <= w_flush_exp ? r_pc[w_head] : r_target[w_head];
      r_fl_code <= w_flush_exp ? r_code[w_head] : '0;
    end
  end

  // Operand lookup: stored result first, then same-cycle writeback bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_hit  <= '0;
      r_rd_data <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!bus.rd_req[k]) begin
          r_rd_hit[k]                  <= 1'b0;
          r_rd_data[k*DATA_W +: DATA_W] <= '0;
        end else if (r_valid[bus.rd_tag[k*TW +: TW]] && r_done[bus.rd_tag[k*TW +: TW]]) begin
          r_rd_hit[k]                  <= 1'b1;
          r_rd_data[k*DATA_W +: DATA_W] <= r_data[bus.rd_tag[k*TW +: TW]];
        end else if (w_wr_hit[bus.rd_tag[k*TW +: TW]]) begin
          r_rd_hit[k]                  <= 1'b1;
          r_rd_data[k*DATA_W +: DATA_W] <= w_wr_data[bus.rd_tag[k*TW +: TW]];
        end else begin
          r_rd_hit[k]                  <= 1'b0;
          r_rd_data[k*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end

  // Outputs
  assign bus.alloc_ready     = w_alloc_ready;
  assign bus.alloc_tag       = w_alloc_tag;
  assign bus.rd_hit          = r_rd_hit;
  assign bus.rd_data         = r_rd_data;
  assign bus.commit_valid    = {w_lane1, w_lane0};
  assign bus.commit_dst_wen  = {w_lane1 && r_wen[w_head1], w_lane0 && r_wen[w_head]};
  assign bus.commit_dst_addr = {w_lane1 ? r_dst[w_head1] : AREG_W'(0),
                                w_lane0 ? r_dst[w_head]  : AREG_W'(0)};
  assign bus.commit_data     = {w_lane1 ? r_data[w_head1] : DATA_W'(0),
                                w_lane0 ? r_data[w_head]  : DATA_W'(0)};
  assign bus.redirect_valid  = (r_state == ST_FLUSH) && r_fl_mis;
  assign bus.redirect_pc     = bus.redirect_valid ? r_fl_pc : '0;
  assign bus.exp_valid       = (r_state == ST_FLUSH) && r_fl_exp;
  assign bus.exp_code        = bus.exp_valid ? r_fl_code : '0;
  assign bus.exp_pc          = bus.exp_valid ? r_fl_pc : '0;
  assign bus.rob_count       = w_count;
  assign bus.rob_full        = w_full;
  assign bus.rob_empty       = (w_count == '0);
endmodule
